// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group width,
// group-count helper and the per-group propagate/generate pair.
package cla_pkg;

    localparam int GROUP_W = 4;

    function automatic int ngroups(input int width);
        return width / GROUP_W;
    endfunction

    typedef struct packed {
        logic gp;
        logic gg;
    } grp_pg_t;

endpackage

// File: rtl/cla_group4.sv
// One 4-bit lookahead group: group propagate/generate plus the carries into
// bits 1..3, computed as if the group carry-in were zero.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    output logic               gp,
    output logic               gg,
    output logic [GROUP_W-2:0] cl
);

    assign gp = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    // The group carry-in term is folded in later, once the group carries are known.
    assign cl[0] = g[0];
    assign cl[1] = g[1] | (p[1] & g[0]);
    assign cl[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_carry_pipe.sv
// Two-stage valid/ready carry-lookahead adder over propagate/generate inputs.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module cla_carry_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] prop,
    input  logic [WIDTH-1:0] gen,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef CLA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NG = ngroups(WIDTH);

    grp_pg_t [NG-1:0]            pg_next;
    grp_pg_t [NG-1:0]            pg_reg;
    logic    [NG-1:0][GROUP_W-2:0] cl_next;
    logic    [NG-1:0][GROUP_W-2:0] cl_reg;
    logic    [WIDTH-1:0]         prop_reg;
    logic                        cin_reg;
    logic                        s1_valid_reg;
    logic                        s2_valid_reg;
    logic    [WIDTH-1:0]         sum_reg;
    logic                        cout_reg;
`ifdef CLA_OVF_EN
    logic                        ovf_reg;
`endif
    logic                        s1_load;
    logic                        s2_load;
    logic    [NG:0]              cg;
    logic    [WIDTH:0]           c;
    logic                        acc;
    logic                        pp;

    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    assign out_valid = s2_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
`ifdef CLA_OVF_EN
    assign ovf       = ovf_reg;
`endif

    // Group carries flattened into two-level lookahead form from cin.
    always_comb begin
        cg    = '0;
        acc   = 1'b0;
        pp    = 1'b0;
        cg[0] = cin_reg;
        for (int j = 0; j < NG; j++) begin
            acc = pg_reg[j].gg;
            pp  = pg_reg[j].gp;
            for (int k = j - 1; k >= 0; k--) begin
                acc = acc | (pp & pg_reg[k].gg);
                pp  = pp & pg_reg[k].gp;
            end
            cg[j+1] = acc | (pp & cin_reg);
        end
    end

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_grp
            cla_group4 u_grp (
                .p  (prop[gi*GROUP_W +: GROUP_W]),
                .g  (gen[gi*GROUP_W +: GROUP_W]),
                .gp (pg_next[gi].gp),
                .gg (pg_next[gi].gg),
                .cl (cl_next[gi])
            );

            assign c[gi*GROUP_W]     = cg[gi];
            assign c[gi*GROUP_W + 1] = cl_reg[gi][0] | (prop_reg[gi*GROUP_W] & cg[gi]);
            assign c[gi*GROUP_W + 2] = cl_reg[gi][1] | ((&prop_reg[gi*GROUP_W +: 2]) & cg[gi]);
            assign c[gi*GROUP_W + 3] = cl_reg[gi][2] | ((&prop_reg[gi*GROUP_W +: 3]) & cg[gi]);
        end
    endgenerate

    assign c[WIDTH] = cg[NG];

    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            prop_reg <= prop;
            cin_reg  <= cin;
            pg_reg   <= pg_next;
            cl_reg   <= cl_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
`ifdef CLA_OVF_EN
            ovf_reg      <= 1'b0;
`endif
        end else begin
            if (s1_load) begin
                s1_valid_reg <= in_valid;
            end
            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
            end
            // Result registers only move on a real stage-1 to stage-2 transfer.
            if (s2_load && s1_valid_reg) begin
                sum_reg  <= prop_reg ^ c[WIDTH-1:0];
                cout_reg <= c[WIDTH];
`ifdef CLA_OVF_EN
                ovf_reg  <= c[WIDTH] ^ c[WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_carry_pipe.sv
// Scoreboard bench for cla_carry_pipe (WIDTH=8): directed vectors, stall,
// mid-flight reset and random traffic; ovf is checked when CLA_OVF_EN is set.
module tb_cla_carry_pipe;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] prop = '0;
    logic [7:0] gen = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
`ifdef CLA_OVF_EN
    logic       ovf;
`endif

    exp_t exp_q[$];
    exp_t pend;
    exp_t got;
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    bit   verbose = 1'b1;
    bit   stall_q = 1'b0;
    logic [7:0] held_sum;
    logic       held_cout;

    // Directed vectors with hand-computed results (prop, gen, cin -> sum, cout, ovf).
    logic [7:0] vp[8]  = '{8'h66, 8'hFE, 8'hFF, 8'h0F, 8'h03, 8'h80, 8'h00, 8'h7F};
    logic [7:0] vg[8]  = '{8'h18, 8'h01, 8'h00, 8'hF0, 8'h03, 8'h00, 8'h00, 8'h00};
    logic       vc[8]  = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    logic [7:0] vs[8]  = '{8'h96, 8'h00, 8'h00, 8'hEF, 8'h04, 8'h80, 8'h01, 8'h80};
    logic       vco[8] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
    logic       vo[8]  = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};

    always #5 clk = ~clk;

    cla_carry_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prop      (prop),
        .gen       (gen),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef CLA_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [7:0] p, input logic [7:0] g, input logic ci,
                         input logic [7:0] es, input logic ec, input logic eo);
        pend     = '{sum: es, cout: ec, ovf: eo};
        prop     = p;
        gen      = g;
        cin      = ci;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(pend);
                if (verbose)
                    $display("txn in  prop=%02h gen=%02h cin=%0d", prop, gen, cin);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept_within_200");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int i);
        issue(vp[i], vg[i], vc[i], vs[i], vco[i], vo[i]);
        wait_accept();
    endtask

    task automatic send_rand();
        logic [7:0] a, b;
        logic       ci;
        logic [8:0] full;
        logic [7:0] low;
        a    = 8'($urandom);
        b    = 8'($urandom);
        ci   = 1'($urandom);
        full = {1'b0, a} + {1'b0, b} + 9'(ci);
        low  = {1'b0, a[6:0]} + {1'b0, b[6:0]} + 8'(ci);
        issue(a ^ b, a & b, ci, full[7:0], full[8], full[8] ^ low[7]);
        wait_accept();
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(3) != 0);
        end
    end

    // Output monitor: pops on each output transfer and checks hold-while-stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_sum", 32'(sum), 32'(held_sum));
                check("hold_cout", 32'(cout), 32'(held_cout));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=sum_%02h required=no_result", sum);
                end else begin
                    got = exp_q.pop_front();
                    check("sum", 32'(sum), 32'(got.sum));
                    check("cout", 32'(cout), 32'(got.cout));
`ifdef CLA_OVF_EN
                    check("ovf", 32'(ovf), 32'(got.ovf));
`endif
                    if (verbose)
                        $display("txn out sum=%02h cout=%0d", sum, cout);
                end
            end
            stall_q   = out_valid && !out_ready;
            held_sum  = sum;
            held_cout = cout;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_vec(i);
        drain();

        // Three back-to-back ops into a stalled output.
        out_ready = 1'b0;
        send_vec(0);
        send_vec(1);
        issue(vp[2], vg[2], vc[2], vs[2], vco[2], vo[2]);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_accept();
        drain();

        // Reset with two ops in flight: both must vanish.
        out_ready = 1'b0;
        send_vec(3);
        send_vec(4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_vec(5);
        drain();

        // Random traffic with random backpressure.
        verbose    = 1'b0;
        rand_ready = 1'b1;
        for (int n = 0; n < 10000; n++) send_rand();
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
